alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_mul_seq.sv | 79 +++++++
 rtl/alu_exec.sv | 124 ++++++++++++
 tb/tb_alu_exec.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution block: default width, op-codes
// and the controller state encoding.
package alu_pkg;

   localparam int XLEN = 32;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_MUL  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SHL  = 4'b1000;
   localparam logic [3:0] OP_SHR  = 4'b1001;
   localparam logic [3:0] OP_SEQ  = 4'b1011;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_NAND = 4'b1101;
   localparam logic [3:0] OP_NOP  = 4'b1111;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MUL_BUSY = 2'd1,
      DONE     = 2'd2
   } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one multiplier bit per cycle, returns the low XLEN
// bits of the product with a one-cycle done pulse.
module alu_mul_seq #(
   parameter int XLEN       = 32,
   parameter int MUL_CYCLES = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            start,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] product
);
   import alu_pkg::*;

   localparam int CW = $clog2(MUL_CYCLES + 1);

   logic [XLEN-1:0] mcand_q, mcand_d;
   logic [XLEN-1:0] mplier_q, mplier_d;
   logic [XLEN-1:0] acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      if (clear) begin
         busy_d = 1'b0;
         cnt_d  = '0;
      end else if (start) begin
         mcand_d  = a;
         mplier_d = b;
         acc_d    = '0;
         cnt_d    = '0;
         busy_d   = 1'b1;
      end else if (busy_q) begin
         if (mplier_q[0])
            acc_d = acc_q + mcand_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         if (cnt_q == CW'(MUL_CYCLES - 1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            cnt_d  = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign done    = done_q;
   assign product = acc_q;

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage with valid/ready handshake: single-cycle logic/arith ops
// and an iterative multiplier behind a three-state controller.
module alu_exec #(
   parameter int XLEN       = alu_pkg::XLEN,
   parameter int MUL_CYCLES = alu_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_ctrl,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [4:0]      shamt,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);
   import alu_pkg::*;

   state_e          state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            illegal_q, illegal_d;
   logic [XLEN-1:0] alu_res;
   logic            alu_ill;
   logic            accept;
   logic            mul_start;
   logic            mul_done;
   logic [XLEN-1:0] mul_product;

   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      case (alu_ctrl)
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_ADD:  alu_res = a + b;
         OP_SUB:  alu_res = a - b;
         OP_NOR:  alu_res = ~(a | b);
         OP_NAND: alu_res = ~(a & b);
         OP_SHL:  alu_res = b << shamt;
         OP_SHR:  alu_res = b >> shamt;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SEQ:  alu_res = {{(XLEN-1){1'b0}}, (a == b)};
         OP_NOP:  alu_res = '0;
         OP_MUL:  alu_res = '0;
         default: alu_ill = 1'b1;
      endcase
   end

   assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      illegal_d = illegal_q;
      mul_start = 1'b0;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (accept) begin
                  if (alu_ctrl == OP_MUL) begin
                     state_d   = MUL_BUSY;
                     mul_start = 1'b1;
                     illegal_d = 1'b0;
                  end else begin
                     state_d   = DONE;
                     result_d  = alu_res;
                     illegal_d = alu_ill;
                  end
               end else if (state_q == DONE && out_ready) begin
                  state_d = IDLE;
               end
            end
            MUL_BUSY: begin
               if (mul_done) begin
                  state_d  = DONE;
                  result_d = mul_product;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         result_q  <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         illegal_q <= illegal_d;
      end
   end

   alu_mul_seq #(
      .XLEN       (XLEN),
      .MUL_CYCLES (MUL_CYCLES)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (flush),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_product)
   );

   // zero is qualified by out_valid so it reads 0 out of reset while result is 0
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign zero      = out_valid && (result_q == '0);
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec.
module tb_alu_exec;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_ctrl;
   logic [31:0] a, b;
   logic [4:0]  shamt;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_exec #(.XLEN(32), .MUL_CYCLES(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctrl  (alu_ctrl),
      .a         (a),
      .b         (b),
      .shamt     (shamt),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   task automatic issue(input logic [3:0] c, input logic [31:0] av,
                        input logic [31:0] bv, input logic [4:0] sh);
      alu_ctrl = c; a = av; b = bv; shamt = sh; in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL issue_ready ctrl=%b in_ready=%b required 1", c, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; alu_ctrl = 4'b0; a = '0; b = '0;
      shamt = '0; flush = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0 || illegal !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs out_valid=%b result=%h zero=%b illegal=%b required 0/0/0/0",
                  out_valid, result, zero, illegal);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready in_ready=%b required 1", in_ready);
      end
   endtask

   task automatic test_single_cycle();
      logic [3:0]  tc [14] = '{4'b0010, 4'b0110, 4'b0111, 4'b0000, 4'b0001, 4'b1100, 4'b1101,
                               4'b1000, 4'b1001, 4'b1011, 4'b0111, 4'b0010, 4'b0100, 4'b1111};
      logic [31:0] ta [14] = '{32'd5, 32'd3, 32'hFFFF_FFFF, 32'hF0F0_1234, 32'hF000_0000, 32'd0,
                               32'hFFFF_FFFF, 32'd0, 32'd0, 32'd9, 32'd1, 32'hFFFF_FFFF,
                               32'd5, 32'd5};
      logic [31:0] tb [14] = '{32'd7, 32'd3, 32'd1, 32'h0FF0_FF00, 32'h0000_000F, 32'd0,
                               32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'd9, 32'hFFFF_FFFF,
                               32'd2, 32'd7, 32'd7};
      logic [4:0]  ts [14] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
                               5'd31, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
      logic [31:0] te [14] = '{32'd12, 32'd0, 32'd1, 32'h00F0_1200, 32'hF000_000F, 32'hFFFF_FFFF,
                               32'd0, 32'h8000_0000, 32'h0800_0000, 32'd1, 32'd0, 32'd1,
                               32'd0, 32'd0};
      logic        tz [14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                               1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic        ti [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         issue(tc[i], ta[i], tb[i], ts[i]);
         checks++;
         if (out_valid !== 1'b1 || result !== te[i] || zero !== tz[i] || illegal !== ti[i]) begin
            failures++;
            $display("FAIL single_op ctrl=%b got v=%b r=%h z=%b i=%b required v=1 r=%h z=%b i=%b",
                     tc[i], out_valid, result, zero, illegal, te[i], tz[i], ti[i]);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_drain out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  bc [3] = '{4'b0010, 4'b0110, 4'b1000};
      logic [31:0] ba [3] = '{32'd1, 32'd10, 32'd0};
      logic [31:0] bb [3] = '{32'd2, 32'd4, 32'd3};
      logic [4:0]  bs [3] = '{5'd0, 5'd0, 5'd2};
      logic [31:0] be [3] = '{32'd3, 32'd6, 32'd12};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         alu_ctrl = bc[i]; a = ba[i]; b = bb[i]; shamt = bs[i]; in_valid = 1'b1;
         checks++;
         if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready op=%0d in_ready=%b required 1", i, in_ready);
         end
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || result !== be[i]) begin
            failures++;
            $display("FAIL b2b_result op=%0d v=%b r=%h required v=1 r=%h", i, out_valid, result, be[i]);
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_mul_hold();
      int  rise = -1;
      logic busy_ready_seen = 1'b0;
      logic [31:0] held;
      out_ready = 1'b0;
      issue(4'b0011, 32'hFFFF_FFFF, 32'd2, 5'd0);
      // present a competing request while busy; it must be ignored
      alu_ctrl = 4'b0010; a = 32'd1; b = 32'd1; in_valid = 1'b1;
      if (in_ready !== 1'b0) busy_ready_seen = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) begin
            rise = i;
            break;
         end
         if (in_ready !== 1'b0) busy_ready_seen = 1'b1;
      end
      checks++;
      if (rise != 33) begin
         failures++;
         $display("FAIL mul_latency out_valid rose after %0d edges required 33", rise);
      end
      checks++;
      if (busy_ready_seen !== 1'b0) begin
         failures++;
         $display("FAIL mul_busy_ready in_ready went high during MUL_BUSY required 0");
      end
      checks++;
      if (result !== 32'hFFFF_FFFE || zero !== 1'b0 || illegal !== 1'b0) begin
         failures++;
         $display("FAIL mul_result r=%h z=%b i=%b required r=fffffffe z=0 i=0", result, zero, illegal);
      end
      held = result;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || result !== held || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL done_hold cycle=%0d v=%b r=%h rdy=%b required v=1 r=%h rdy=0",
                     i, out_valid, result, in_ready, held);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL done_release v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_mul_wrap();
      logic [31:0] ma [2] = '{32'h0001_0000, 32'd12345};
      logic [31:0] mb [2] = '{32'h0001_0000, 32'd1000};
      logic [31:0] me [2] = '{32'd0, 32'd12345000};
      logic        mz [2] = '{1'b1, 1'b0};
      out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         logic seen = 1'b0;
         issue(4'b0011, ma[k], mb[k], 5'd0);
         for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
               seen = 1'b1;
               checks++;
               if (result !== me[k] || zero !== mz[k]) begin
                  failures++;
                  $display("FAIL mul_wrap k=%0d r=%h z=%b required r=%h z=%b",
                           k, result, zero, me[k], mz[k]);
               end
            end
         end
         checks++;
         if (seen !== 1'b1) begin
            failures++;
            $display("FAIL mul_timeout k=%0d out_valid never rose required rise within 40", k);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_flush();
      logic rose = 1'b0;
      out_ready = 1'b1;
      issue(4'b0011, 32'd7, 32'd9, 5'd0);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_mul v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
      end
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) rose = 1'b1;
      end
      checks++;
      if (rose !== 1'b0) begin
         failures++;
         $display("FAIL flush_no_result out_valid rose after flush required never");
      end
      alu_ctrl = 4'b0010; a = 32'd5; b = 32'd7; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_transfer v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_mul();
      logic rose = 1'b0;
      out_ready = 1'b1;
      issue(4'b0011, 32'd3, 32'd4, 5'd0);
      repeat (9) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || result !== 32'd0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL async_reset v=%b r=%h rdy=%b required v=0 r=0 rdy=1", out_valid, result, in_ready);
      end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_mul_ready in_ready=%b required 1", in_ready);
      end
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) rose = 1'b1;
      end
      checks++;
      if (rose !== 1'b0) begin
         failures++;
         $display("FAIL reset_no_result out_valid rose after reset required never");
      end
   endtask

   initial begin
      test_reset();
      test_single_cycle();
      test_back_to_back();
      test_mul_hold();
      test_mul_wrap();
      test_flush();
      test_reset_mid_mul();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
